univ_mod_counter: RTL and testbench
===================================

// Module: univ_mod_counter
// PURPOSE
//  Parametrised successor of the universal binary counter: modulo-M up/down counter with
//  programmable step, selectable overflow mode (wrap / saturate / one-shot), compare match
//  and wrap event. Timer/prescaler building block for later chapters (PWM, baud gen, debouncers).
// PARAMETERS
//  N       8    counter width in bits
//  M       256  modulus; count range 0..M-1; 2 <= M <= 2**N
//  STEP_W  4    width of step input
// PORTS
//  clk      in   1       single clock, all state updates on rising edge
//  reset    in   1       synchronous, active-low (reset==0 at rising clk resets)
//  syn_clr  in   1       synchronous clear to 0
//  load     in   1       synchronous load of d
//  d        in   N       load value
//  en       in   1       count enable
//  up       in   1       1 = count up, 0 = count down
//  step     in   STEP_W  increment/decrement per enabled cycle
//  mode     in   2       00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
//  start    in   1       arms one-shot run (ignored in other modes)
//  cmp      in   N       compare value
//  q        out  N       count value
//  max_tick out  1       comb: q == M-1
//  min_tick out  1       comb: q == 0
//  cmp_match out 1       comb: q == cmp
//  wrap_tick out 1       registered 1-cycle pulse: previous update crossed modulus boundary
//  busy     out  1       one-shot FSM in RUN
//  done     out  1       one-shot FSM in DONE
// BEHAVIOUR
//  - Reset: q=0, FSM=IDLE, wrap_tick=0, busy=0, done=0. Reset mid-run aborts with no tick.
//  - Priority per cycle: reset > syn_clr > load > count. syn_clr/load never raise wrap_tick.
//  - load: q <= (d > M-1) ? M-1 : d. syn_clr: q <= 0, FSM -> IDLE.
//  - Count happens when en=1 and (mode!=one-shot or FSM==RUN). step==0: q holds, no tick.
//  - step_eff = (step > M-1) ? M-1 : step. Sums computed N+1 bits wide, no truncation.
//  - Up:   s=q+step_eff; s<=M-1 -> q<=s; else wrap: q<=s-M, wrap_tick<=1;
//          saturate: q<=M-1; one-shot: q<=M-1, FSM->DONE.
//  - Down: step_eff<=q -> q<=q-step_eff; else wrap: q<=q+M-step_eff, wrap_tick<=1;
//          saturate: q<=0; one-shot: q<=0, FSM->DONE.
//  - Exact landing on M-1 (up) or 0 (down) is NOT overflow: q updates, no wrap/DONE.
//  - Saturate at limit with en=1: q holds, no tick.
//  - wrap_tick high exactly the cycle after the wrapping edge, else 0.
//  - One-shot FSM: IDLE --start--> RUN; RUN --overflow--> DONE; DONE --start--> RUN
//    (q unchanged; reload first via load). syn_clr -> IDLE from any state.
//    load does not change FSM state. start in RUN ignored.
//  - busy = (FSM==RUN), done = (FSM==DONE), both registered.
//  - mode sampled each cycle; when mode!=one-shot the FSM is forced to IDLE next edge.
//  - up/step/mode changes take effect on the very next enabled edge; no pipelining.
// STRUCTURE
//  - Package univ_cnt_pkg: mode constants (MODE_WRAP/SAT/ONESHOT), FSM state encoding
//    (ST_IDLE/ST_RUN/ST_DONE).
//  - Sub-module mod_step_next (combinational): q, step_eff, up, M -> next value,
//    overflow flag; top holds q register, FSM, tick register, compare logic.
// TESTING  (bench with N=4, M=10, STEP_W=3, T=20 ns)
//  1. reset=0 one cycle with load=1,d=7 -> q=0, ticks/busy/done 0; then load d=7 -> q=7;
//     load d=13 -> q=9, max_tick=1.
//  2. wrap, up, step=3 from q=7 -> 0 (wrap_tick=1 next cycle), 3, 6, 9 (no tick), 2 (tick).
//  3. wrap, down, step=4 from q=2 -> 8 with wrap_tick; q=4 -> 0, min_tick=1, no tick.
//  4. saturate, up, step=2 from q=8 -> 9 -> 9 -> 9, wrap_tick never set; down from 1 -> 0 -> 0.
//  5. one-shot: q=0, en=1, no start -> q holds 0; start -> busy; step=4: 4, 8, 9 and done=1;
//     further en holds 9; load 0 + start -> runs again; syn_clr mid-run -> q=0, IDLE.
//  6. Priority/edge: syn_clr+load+en same cycle -> q=0; en=0 pauses; step=0 holds;
//     cmp=5 -> cmp_match only while q==5; reset=0 mid one-shot run -> all outputs 0.

Source files
------------

// File: rtl/univ_cnt_pkg.sv
// Shared constants for the modulo-M counter: overflow-mode codes and one-shot FSM states.
// No logic here, so there is no latency or backpressure to describe.
package univ_cnt_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mod_step_next.sv
// Computes the next modulo-M value and an overflow flag for one up/down step.
// Combinational (zero latency); no backpressure, the result is consumed every cycle.
module mod_step_next #(
    parameter int N = 8,
    parameter int M = 256
) (
    input  logic [N-1:0] q,
    input  logic [N-1:0] step_eff,
    input  logic         up,
    output logic [N-1:0] nxt,
    output logic         ovf
);

    localparam logic [N:0] MOD  = (N+1)'(M);
    localparam logic [N:0] LAST = (N+1)'(M-1);

    logic [N:0] q_x;
    logic [N:0] s_x;
    logic [N:0] sum;
    logic [N:0] sum_wrap;
    logic [N:0] dif;
    logic [N:0] dif_wrap;

    // One extra bit keeps q+step and q+M-step exact even when M == 2**N.
    assign q_x      = {1'b0, q};
    assign s_x      = {1'b0, step_eff};
    assign sum      = q_x + s_x;
    assign sum_wrap = sum - MOD;
    assign dif      = q_x - s_x;
    assign dif_wrap = q_x + MOD - s_x;

    always_comb begin
        ovf = 1'b0;
        nxt = q;
        if (up) begin
            ovf = (sum > LAST);
            nxt = ovf ? sum_wrap[N-1:0] : sum[N-1:0];
        end else begin
            ovf = (s_x > q_x);
            nxt = ovf ? dif_wrap[N-1:0] : dif[N-1:0];
        end
    end

endmodule

// File: rtl/univ_mod_counter.sv
// Modulo-M up/down counter with programmable step, wrap/saturate/one-shot overflow and compare.
// q, wrap_tick, busy, done update one edge after the inputs; no backpressure, en simply pauses counting.
module univ_mod_counter
    import univ_cnt_pkg::*;
#(
    parameter int N      = 8,
    parameter int M      = 256,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              syn_clr,
    input  logic              load,
    input  logic [N-1:0]      d,
    input  logic              en,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic [N-1:0]      cmp,
    output logic [N-1:0]      q,
    output logic              max_tick,
    output logic              min_tick,
    output logic              cmp_match,
    output logic              wrap_tick,
    output logic              busy,
    output logic              done
);

    localparam int          SW    = (STEP_W > N) ? STEP_W : N;
    localparam logic [SW:0] LIM_S = (SW+1)'(M-1);
    localparam logic [N-1:0] QMAX = N'(M-1);

    state_t         state;
    state_t         st_nxt;
    logic [SW:0]    step_x;
    logic [N-1:0]   step_eff;
    logic [N-1:0]   ld_val;
    logic [N-1:0]   nxt;
    logic           ovf;
    logic           oneshot;
    logic           do_cnt;

    assign step_x   = (SW+1)'(step);
    assign step_eff = (step_x > LIM_S) ? QMAX : step_x[N-1:0];
    assign ld_val   = (d > QMAX) ? QMAX : d;
    assign oneshot  = (mode == MODE_ONESHOT);
    assign do_cnt   = en && (step_eff != '0) && (!oneshot || state == ST_RUN);

    mod_step_next #(.N(N), .M(M)) u_step (
        .q        (q),
        .step_eff (step_eff),
        .up       (up),
        .nxt      (nxt),
        .ovf      (ovf)
    );

    // Leaving one-shot mode parks the FSM in IDLE so a later switch back starts clean.
    always_comb begin
        st_nxt = state;
        if (syn_clr || !oneshot) begin
            st_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) st_nxt = ST_RUN;
                ST_RUN:  if (!load && do_cnt && ovf) st_nxt = ST_DONE;
                ST_DONE: if (start) st_nxt = ST_RUN;
                default: st_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q         <= '0;
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap_tick <= 1'b0;
        end else begin
            state     <= st_nxt;
            busy      <= (st_nxt == ST_RUN);
            done      <= (st_nxt == ST_DONE);
            wrap_tick <= 1'b0;
            if (syn_clr) begin
                q <= '0;
            end else if (load) begin
                q <= ld_val;
            end else if (do_cnt) begin
                if (!ovf) begin
                    q <= nxt;
                end else if (mode == MODE_SAT || oneshot) begin
                    q <= up ? QMAX : '0;
                end else begin
                    q         <= nxt;
                    wrap_tick <= 1'b1;
                end
            end
        end
    end

    assign max_tick  = (q == QMAX);
    assign min_tick  = (q == '0);
    assign cmp_match = (q == cmp);

endmodule

// File: tb/tb_univ_mod_counter.sv
// Directed bench for univ_mod_counter with N=4, M=10, STEP_W=3: vector table plus hand sequences.
module tb_univ_mod_counter;

    logic       clk = 1'b0;
    logic       reset, syn_clr, load, en, up, start;
    logic [3:0] d, cmp, q;
    logic [2:0] step;
    logic [1:0] mode;
    logic       max_tick, min_tick, cmp_match, wrap_tick, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    univ_mod_counter #(.N(4), .M(10), .STEP_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .syn_clr   (syn_clr),
        .load      (load),
        .d         (d),
        .en        (en),
        .up        (up),
        .step      (step),
        .mode      (mode),
        .start     (start),
        .cmp       (cmp),
        .q         (q),
        .max_tick  (max_tick),
        .min_tick  (min_tick),
        .cmp_match (cmp_match),
        .wrap_tick (wrap_tick),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic       rst;
        logic       clr;
        logic       ld;
        logic [3:0] d;
        logic       en;
        logic       up;
        logic [2:0] st;
        logic [1:0] md;
        logic       sta;
        logic [3:0] cmp;
        logic [3:0] eq;
        logic [5:0] ef;   // {max, min, cmp_match, wrap_tick, busy, done}
    } vec_t;

    function automatic vec_t v(input logic rst, input logic clr, input logic ld,
                               input logic [3:0] dd, input logic e, input logic u,
                               input logic [2:0] st, input logic [1:0] md, input logic sta,
                               input logic [3:0] c, input logic [3:0] eq, input logic [5:0] ef);
        vec_t r;
        r.rst = rst; r.clr = clr; r.ld = ld; r.d = dd; r.en = e; r.up = u;
        r.st = st; r.md = md; r.sta = sta; r.cmp = c; r.eq = eq; r.ef = ef;
        return r;
    endfunction

    task automatic check(input string name, input logic [3:0] eq, input logic [5:0] ef);
        logic [9:0] got, exp;
        got = {q, max_tick, min_tick, cmp_match, wrap_tick, busy, done};
        exp = {eq, ef};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got q=%0d flags=%b, expected q=%0d flags=%b (flags max,min,cmp,wrap,busy,done)",
                     name, got[9:6], got[5:0], exp[9:6], exp[5:0]);
        end
    endtask

    task automatic drive(input vec_t x);
        reset = x.rst; syn_clr = x.clr; load = x.ld; d = x.d; en = x.en; up = x.up;
        step = x.st; mode = x.md; start = x.sta; cmp = x.cmp;
    endtask

    task automatic edge_check(input string name, input logic [3:0] eq, input logic [5:0] ef);
        @(posedge clk);
        #1;
        check(name, eq, ef);
        @(negedge clk);
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b0; syn_clr = 1'b0; load = 1'b0; d = '0; en = 1'b0; up = 1'b1;
        step = '0; mode = 2'b00; start = 1'b0; cmp = 4'd15;

        // rst clr ld  d   en up st  md  sta cmp   q  {max,min,cm,wt,b,dn}
        tbl.push_back(v(0, 0, 1, 7,  0, 1, 0, 0, 0, 15, 0, 6'b010000)); // reset beats load
        tbl.push_back(v(1, 0, 1, 7,  0, 1, 0, 0, 0, 15, 7, 6'b000000));
        tbl.push_back(v(1, 0, 1, 13, 0, 1, 0, 0, 0, 15, 9, 6'b100000)); // load clamps to M-1
        tbl.push_back(v(1, 0, 1, 7,  0, 1, 0, 0, 0, 15, 7, 6'b000000));
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 3, 0, 0, 15, 0, 6'b010100)); // 7+3 wraps to 0
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 3, 0, 0, 15, 3, 6'b000000));
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 3, 0, 0, 15, 6, 6'b000000));
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 3, 0, 0, 15, 9, 6'b100000)); // exact landing, no tick
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 3, 0, 0, 15, 2, 6'b000100));
        tbl.push_back(v(1, 0, 0, 0,  1, 0, 4, 0, 0, 15, 8, 6'b000100)); // 2-4 wraps to 8
        tbl.push_back(v(1, 0, 0, 0,  1, 0, 4, 0, 0, 15, 4, 6'b000000));
        tbl.push_back(v(1, 0, 0, 0,  1, 0, 4, 0, 0, 15, 0, 6'b010000));
        tbl.push_back(v(1, 0, 1, 8,  0, 1, 2, 1, 0, 15, 8, 6'b000000));
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 2, 1, 0, 15, 9, 6'b100000)); // saturate
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 2, 1, 0, 15, 9, 6'b100000));
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 2, 1, 0, 15, 9, 6'b100000));
        tbl.push_back(v(1, 0, 1, 1,  0, 0, 2, 1, 0, 15, 1, 6'b000000));
        tbl.push_back(v(1, 0, 0, 0,  1, 0, 2, 1, 0, 15, 0, 6'b010000));
        tbl.push_back(v(1, 0, 0, 0,  1, 0, 2, 1, 0, 15, 0, 6'b010000));
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 4, 2, 0, 15, 0, 6'b010000)); // one-shot idle holds
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 4, 2, 1, 15, 0, 6'b010010)); // start -> RUN
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 4, 2, 0, 15, 4, 6'b000010));
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 4, 2, 0, 15, 8, 6'b000010));
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 4, 2, 0, 15, 9, 6'b100001)); // overflow -> DONE
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 4, 2, 0, 15, 9, 6'b100001));
        tbl.push_back(v(1, 0, 1, 0,  0, 1, 4, 2, 0, 15, 0, 6'b010001)); // load keeps DONE
        tbl.push_back(v(1, 0, 0, 0,  0, 1, 4, 2, 1, 15, 0, 6'b010010));
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 4, 2, 0, 15, 4, 6'b000010));
        tbl.push_back(v(1, 1, 0, 0,  1, 1, 4, 2, 0, 15, 0, 6'b010000)); // syn_clr mid-run
        tbl.push_back(v(1, 0, 1, 3,  0, 1, 1, 0, 0, 15, 3, 6'b000000));
        tbl.push_back(v(1, 1, 1, 3,  1, 1, 1, 0, 0, 15, 0, 6'b010000)); // clr > load > count
        tbl.push_back(v(1, 0, 1, 3,  0, 1, 1, 0, 0, 15, 3, 6'b000000));
        tbl.push_back(v(1, 0, 0, 0,  0, 1, 1, 0, 0, 15, 3, 6'b000000)); // en=0 pauses
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 0, 0, 0, 15, 3, 6'b000000)); // step=0 holds
        tbl.push_back(v(1, 0, 1, 5,  0, 1, 1, 0, 0, 5,  5, 6'b001000));
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 1, 0, 0, 5,  6, 6'b000000));
        tbl.push_back(v(1, 0, 1, 9,  0, 1, 1, 3, 0, 15, 9, 6'b100000));
        tbl.push_back(v(1, 0, 0, 0,  1, 1, 1, 3, 0, 15, 0, 6'b010100)); // mode 11 wraps
        tbl.push_back(v(1, 0, 0, 0,  0, 1, 1, 3, 0, 15, 0, 6'b010000)); // tick is one cycle

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            edge_check($sformatf("vec%0d", i), tbl[i].eq, tbl[i].ef);
        end

        // Reset in the middle of a one-shot run aborts with everything cleared.
        reset = 1'b1; syn_clr = 1'b0; mode = 2'b10; load = 1'b1; d = 4'd0; en = 1'b0;
        up = 1'b1; step = 3'd1; start = 1'b0; cmp = 4'd15;
        edge_check("rst_run_load", 4'd0, 6'b010000);
        load = 1'b0; start = 1'b1;
        edge_check("rst_run_start", 4'd0, 6'b010010);
        start = 1'b0; en = 1'b1;
        edge_check("rst_run_cnt1", 4'd1, 6'b000010);
        edge_check("rst_run_cnt2", 4'd2, 6'b000010);
        reset = 1'b0;
        edge_check("rst_run_abort", 4'd0, 6'b010000);

        // Leaving one-shot mode mid-run drops busy on the next edge.
        reset = 1'b1; en = 1'b0; start = 1'b1;
        edge_check("mode_sw_start", 4'd0, 6'b010010);
        start = 1'b0; mode = 2'b00;
        edge_check("mode_sw_idle", 4'd0, 6'b010000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
